wide_accumulator: RTL and testbench

- Sequencer and register unit placed directly around the 16-bit carry-lookahead adder: it drives the adder's `A`, `B` and `cin` inputs and consumes its `S` and `cout`.
- Implements a 32-bit unsigned running accumulator using two passes through the 16-bit adder: low half first, then high half with the stored carry.
- An operand is captured from the switches on a Run request and added to the accumulator.
- Result and overflow are held for display until Run is released.

---
 rtl/wide_accumulator.sv | 100 ++++++++++
 tb/tb_wide_accumulator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_accumulator.sv
// 32-bit running accumulator sequenced over an external 16-bit adder (low pass, then high pass).
// Optional saturation on 32-bit overflow: define WIDE_ACC_SATURATE_EN.
module wide_accumulator (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Clear,
    input  logic [15:0] SW,
    input  logic [15:0] Adder_S,
    input  logic        Adder_Cout,
    output logic [15:0] Adder_A,
    output logic [15:0] Adder_B,
    output logic        Adder_Cin,
    output logic [31:0] Acc,
    output logic        Ovf,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {StIdle, StAddLo, StAddHi, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] op_q, op_d;
    logic        c_q, c_d;
    logic [31:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            op_q    <= 16'h0000;
            c_q     <= 1'b0;
            acc_q   <= 32'h0000_0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        c_d       = c_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        Adder_A   = acc_q[15:0];
        Adder_B   = 16'h0000;
        Adder_Cin = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Clear wins over Run in the same cycle.
                if (Clear) begin
                    acc_d = 32'h0000_0000;
                    ovf_d = 1'b0;
                end else if (Run) begin
                    op_d    = SW;
                    state_d = StAddLo;
                end
            end
            StAddLo: begin
                Busy          = 1'b1;
                Adder_B       = op_q;
                acc_d[15:0]   = Adder_S;
                c_d           = Adder_Cout;
                state_d       = StAddHi;
            end
            StAddHi: begin
                Busy          = 1'b1;
                Adder_A       = acc_q[31:16];
                Adder_Cin     = c_q;
                acc_d[31:16]  = Adder_S;
                ovf_d         = ovf_q | Adder_Cout;
`ifdef WIDE_ACC_SATURATE_EN
                if (Adder_Cout) begin
                    acc_d = 32'hFFFF_FFFF;
                end
`endif
                state_d       = StHold;
            end
            StHold: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Acc = acc_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_wide_accumulator.sv
// Randomized self-checking bench for wide_accumulator against a plain 33-bit arithmetic model.
module tb_wide_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        clear;
    logic [15:0] sw;
    logic [15:0] adder_s;
    logic        adder_cout;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic        adder_cin;
    logic [31:0] acc;
    logic        ovf;
    logic        busy;
    logic        done;

    // When set, the adder stand-in returns all-ones with no carry, used to preload Acc quickly.
    logic        adder_ovr = 1'b0;
    logic [16:0] adder_sum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_acc = 32'h0;
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    assign adder_sum  = {1'b0, adder_a} + {1'b0, adder_b} + {16'h0, adder_cin};
    assign adder_s    = adder_ovr ? 16'hFFFF : adder_sum[15:0];
    assign adder_cout = adder_ovr ? 1'b0 : adder_sum[16];

    wide_accumulator dut (
        .Clk        (clk),
        .Reset_n    (reset_n),
        .Run        (run),
        .Clear      (clear),
        .SW         (sw),
        .Adder_S    (adder_s),
        .Adder_Cout (adder_cout),
        .Adder_A    (adder_a),
        .Adder_B    (adder_b),
        .Adder_Cin  (adder_cin),
        .Acc        (acc),
        .Ovf        (ovf),
        .Busy       (busy),
        .Done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input logic [15:0] op);
        logic [32:0] sum;
        sum = {1'b0, m_acc} + {17'h0, op};
        if (sum[32]) m_ovf = 1'b1;
`ifdef WIDE_ACC_SATURATE_EN
        m_acc = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
        m_acc = sum[31:0];
`endif
    endtask

    task automatic do_acc(input logic [15:0] op, input int hold, input bit clr_busy);
        logic [16:0] lo;
        lo    = {1'b0, m_acc[15:0]} + {1'b0, op};
        sw    = op;
        run   = 1'b1;
        step();
        check("lo_busy", 32'(busy), 32'd1);
        check("lo_a", 32'(adder_a), 32'(m_acc[15:0]));
        check("lo_b", 32'(adder_b), 32'(op));
        check("lo_cin", 32'(adder_cin), 32'd0);
        sw    = 16'($urandom);
        clear = clr_busy;
        step();
        check("hi_busy", 32'(busy), 32'd1);
        check("hi_a", 32'(adder_a), 32'(m_acc[31:16]));
        check("hi_b", 32'(adder_b), 32'd0);
        check("hi_cin", 32'(adder_cin), 32'(lo[16]));
        check("hi_acc_lo", 32'(acc[15:0]), 32'(lo[15:0]));
        step();
        model_add(op);
        check("hold_done", 32'(done), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_acc", acc, m_acc);
        check("hold_ovf", 32'(ovf), 32'(m_ovf));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_stay", 32'(done), 32'd1);
            check("hold_acc_stay", acc, m_acc);
        end
        run   = 1'b0;
        clear = 1'b0;
        step();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_acc", acc, m_acc);
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        clear   = 1'b0;
        sw      = 16'h0;
        #1;
        check("rst_acc", acc, 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_a", 32'(adder_a), 32'd0);
        check("rst_b", 32'(adder_b), 32'd0);
        check("rst_cin", 32'(adder_cin), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        do_acc(16'h1234, 0, 1'b0);
        do_acc(16'hEDCB, 1, 1'b0);
        check("acc_ffff", acc, 32'h0000_FFFF);
        do_acc(16'h0001, 0, 1'b0);
        check("carry_acc", acc, 32'h0001_0000);
        check("carry_ovf", 32'(ovf), 32'd0);

        // Preload Acc to all ones through the adder override.
        adder_ovr = 1'b1;
        run       = 1'b1;
        step();
        step();
        step();
        run = 1'b0;
        step();
        adder_ovr = 1'b0;
        m_acc     = 32'hFFFF_FFFF;
        check("preload_acc", acc, 32'hFFFF_FFFF);
        do_acc(16'h0002, 0, 1'b0);
`ifdef WIDE_ACC_SATURATE_EN
        check("wrap_acc", acc, 32'hFFFF_FFFF);
`else
        check("wrap_acc", acc, 32'h0000_0001);
`endif
        check("wrap_ovf", 32'(ovf), 32'd1);
        do_acc(16'h0100, 0, 1'b1);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Clear and Run together in IDLE: clear only, start next cycle.
        clear = 1'b1;
        run   = 1'b1;
        sw    = 16'h5555;
        step();
        m_acc = 32'h0;
        m_ovf = 1'b0;
        check("clr_acc", acc, 32'h0);
        check("clr_ovf", 32'(ovf), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        clear = 1'b0;
        do_acc(16'h5555, 0, 1'b0);

        do_acc(16'h0010, 20, 1'b0);
        check("oneshot_acc", acc, 32'h0000_5565);

        // Reset during ADD_HI discards the partial result.
        sw  = 16'hABCD;
        run = 1'b1;
        step();
        step();
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        m_acc = 32'h0;
        m_ovf = 1'b0;
        check("mid_rst_acc", acc, 32'h0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        run = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_acc", acc, 32'h0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
                m_acc = 32'h0;
                m_ovf = 1'b0;
                check("rnd_clr", acc, 32'h0);
            end
            do_acc(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
